alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- ID/EX control stage that produces the ALU's 3-bit operation code: the encoder side of the ALUctrl interface.
- Decodes opcode/funct3/funct7[5] of each instruction into ALUctrl, operand selects and branch flags.
- Registers the decoded fields into the EX stage with valid, stall and flush control.
- Flags instructions the ALU encoding cannot execute (SLT/SLTU/SRA/unknown) as illegal.

Parameters:
- CTRL_WIDTH, 3, width of ALUctrl; fixed by the ALU encoding, not intended to change.
- OPCODE_WIDTH, 7, RV32I opcode field width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ID holds a valid instruction
- opcode  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- stall  in  1  hold EX register contents
- flush  in  1  kill the instruction being captured (branch taken / redirect)
- out_valid  out  1  EX-stage instruction valid
- ALUctrl  out  3  to the ALU: 000 add, 001 sub, 010 sll, 011 reserved, 100 xor, 101 srl, 110 or, 111 and
- ALUsrc  out  1  op2 select: 0 = rs2, 1 = immediate
- op1_sel  out  2  op1 select: 00 = rs1, 01 = PC, 10 = zero
- branch  out  1  EX branch instruction
- branch_ne  out  1  1 = BNE (taken on !Zero), 0 = BEQ (taken on Zero)
- illegal  out  1  EX instruction undecodable or unsupported
- illegal_seen  out  1  sticky flag: an illegal instruction has reached EX since reset

Behaviour:
- Reset: synchronous, applied when rst_n == 0 at a clock edge. All outputs go to 0 (ALUctrl = 000, op1_sel = 00, illegal_seen = 0).
- Latency: 1 cycle. Fields decoded from the inputs at edge N appear on the outputs after edge N.
- Priority per edge: reset > flush > stall > load.
  - Flush: outputs become a bubble (out_valid = 0, all control fields 0). Flush overrides stall.
  - Stall (no flush): all outputs hold their values, including illegal_seen.
  - Load: captures the decode when in_valid = 1; captures a bubble when in_valid = 0.
- Decode, combinational:
  - R-type (0110011):
    - funct3 000: add when f7_5 = 0, sub when f7_5 = 1.
    - 001: sll. 100: xor. 110: or. 111: and.
    - 101: srl when f7_5 = 0, illegal when f7_5 = 1.
    - 010/011: illegal.
    - ALUsrc = 0, op1_sel = rs1.
  - I-ALU (0010011): same funct3 map, with these differences:
    - 000 is always add.
    - 001 requires f7_5 = 0, else illegal.
    - 101 with f7_5 = 1 (srai) is illegal.
    - ALUsrc = 1.
  - Load (0000011), Store (0100011), JALR (1100111): add, ALUsrc = 1, op1_sel = rs1.
  - Branch (1100011): sub, ALUsrc = 0, branch = 1.
    - funct3 000: branch_ne = 0.
    - funct3 001: branch_ne = 1.
    - Any other funct3: illegal.
  - LUI (0110111): add, ALUsrc = 1, op1_sel = zero.
  - AUIPC (0010111), JAL (1101111): add, ALUsrc = 1, op1_sel = PC.
  - Any other opcode: illegal.
- Illegal instruction:
  - Captured with out_valid = 1, illegal = 1, all other control fields 0 (add/rs1/rs2/no branch).
  - ALUctrl 011 is never emitted.
- illegal_seen: set on the edge that loads an illegal instruction (valid, not flushed). Cleared only by reset.
- Bubble: illegal = 0 and does not affect illegal_seen.

Decomposition:
- Package alu_pkg:
  - localparams ALU_ADD/SUB/SLL/XOR/SRL/OR/AND with the encoding above.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR.
  - Enum op1_sel_t {OP1_RS1, OP1_PC, OP1_ZERO}.
  - Packed struct alu_ctrl_t bundling ALUctrl, ALUsrc, op1_sel, branch, branch_ne, illegal.
- Sub-module alu_ctrl_decode: purely combinational, opcode/funct3/funct7_5 -> alu_ctrl_t. alu_ctrl_stage is the register/valid/stall/flush wrapper around it.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with in_valid = 1, opcode = 0110011 -> all outputs 0. First valid load after release appears exactly 1 cycle later.
- R-type sweep: opcode 0110011, funct3 000 f7_5 = 1 -> ALUctrl 001. funct3 101 f7_5 = 0 -> 101. funct3 010 -> illegal = 1, ALUctrl 000, illegal_seen rises next edge.
- Branch/LUI/AUIPC:
  - 1100011 funct3 001 -> ALUctrl 001, branch = 1, branch_ne = 1, ALUsrc = 0.
  - 0110111 -> op1_sel 10, ALUsrc = 1.
  - 0010111 -> op1_sel 01.
- Stall: load ADDI, then stall = 1 for 3 cycles while presenting XOR -> outputs stay ADDI (000, ALUsrc = 1). XOR (100) appears the cycle after stall drops.
- Flush priority: stall = 1 and flush = 1 on the same edge with an illegal instruction at the inputs -> out_valid = 0, all fields 0, illegal_seen stays 0.
- Bubble: in_valid = 0 with opcode = 1111111 -> out_valid = 0, illegal = 0, illegal_seen unchanged. Reset mid-stall clears illegal_seen.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU control package: the ALUctrl encoding, RV32I opcode constants and
// the bundle of decoded control fields that travels from ID into EX.
package alu_pkg;

    localparam int CTRL_WIDTH   = 3;
    localparam int OPCODE_WIDTH = 7;

    // ALUctrl encoding seen by the ALU. 3'b011 is reserved and never driven.
    localparam logic [CTRL_WIDTH-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_WIDTH-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_WIDTH-1:0] ALU_SLL = 3'b010;
    localparam logic [CTRL_WIDTH-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_WIDTH-1:0] ALU_SRL = 3'b101;
    localparam logic [CTRL_WIDTH-1:0] ALU_OR  = 3'b110;
    localparam logic [CTRL_WIDTH-1:0] ALU_AND = 3'b111;

    // RV32I major opcodes (instr[6:0]).
    localparam logic [OPCODE_WIDTH-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_WIDTH-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10
    } op1_sel_t;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] alu_ctrl;
        logic                  alu_src;    // 0 = rs2, 1 = immediate
        op1_sel_t              op1_sel;
        logic                  branch;
        logic                  branch_ne;  // 1 = BNE, 0 = BEQ
        logic                  illegal;
    } alu_ctrl_t;

    // All-zero control word: what a bubble carries into EX.
    localparam alu_ctrl_t CTRL_BUBBLE = '{
        alu_ctrl:  ALU_ADD,
        alu_src:   1'b0,
        op1_sel:   OP1_RS1,
        branch:    1'b0,
        branch_ne: 1'b0,
        illegal:   1'b0
    };

endpackage : alu_pkg

// File: rtl/alu_ctrl_decode.sv
// Combinational ID-stage decoder: opcode / funct3 / funct7[5] -> alu_ctrl_t.
// Instructions the 3-bit ALU cannot execute (SLT, SLTU, SRA/SRAI, unknown
// opcodes, bad branch funct3) come out as an all-zero word with illegal = 1.
//   opcode   in  instr[6:0]
//   funct3   in  instr[14:12]
//   funct7_5 in  instr[30]
//   ctrl     out decoded control word
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    output alu_ctrl_t               ctrl
);

    alu_ctrl_t raw;
    logic      bad;

    always_comb begin
        // NOTE: every field gets a default before the case so no path through
        // the decode leaves a signal unassigned and infers a latch.
        raw = CTRL_BUBBLE;
        bad = 1'b0;

        unique case (opcode)
            OP_R, OP_I: begin
                raw.alu_src = (opcode == OP_I);
                unique case (funct3)
                    // Immediate form has no SUB: ADDI ignores instr[30].
                    3'b000: raw.alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        raw.alu_ctrl = ALU_SLL;
                        bad          = (opcode == OP_I) && funct7_5;
                    end
                    3'b100: raw.alu_ctrl = ALU_XOR;
                    3'b101: begin
                        // instr[30] selects SRA/SRAI, which this ALU lacks.
                        raw.alu_ctrl = ALU_SRL;
                        bad          = funct7_5;
                    end
                    3'b110: raw.alu_ctrl = ALU_OR;
                    3'b111: raw.alu_ctrl = ALU_AND;
                    default: bad = 1'b1;   // SLT / SLTU
                endcase
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
                raw.alu_src = 1'b1;
            end
            OP_BRANCH: begin
                raw.alu_ctrl  = ALU_SUB;
                raw.branch    = 1'b1;
                raw.branch_ne = (funct3 == 3'b001);
                bad           = (funct3 != 3'b000) && (funct3 != 3'b001);
            end
            OP_LUI: begin
                raw.alu_src = 1'b1;
                raw.op1_sel = OP1_ZERO;
            end
            OP_AUIPC, OP_JAL: begin
                raw.alu_src = 1'b1;
                raw.op1_sel = OP1_PC;
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal words carry no partial decode into EX.
    always_comb begin
        ctrl = raw;
        if (bad) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.illegal = 1'b1;
        end
    end

endmodule : alu_ctrl_decode

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control stage. Decodes the ID instruction and registers the
// control word into EX with valid, stall and flush handling.
// Per-edge priority: reset > flush > stall > load.
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid         ID holds a valid instruction
//   opcode/funct3/funct7_5  instruction fields
//   stall            hold EX contents (including illegal_seen)
//   flush            capture a bubble instead of the ID instruction
//   out_valid        EX instruction valid
//   ALUctrl, ALUsrc, op1_sel, branch, branch_ne, illegal  EX control fields
//   illegal_seen     sticky: an illegal instruction reached EX since reset
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int CTRL_WIDTH   = alu_pkg::CTRL_WIDTH,
    parameter int OPCODE_WIDTH = alu_pkg::OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [CTRL_WIDTH-1:0]   ALUctrl,
    output logic                    ALUsrc,
    output logic [1:0]              op1_sel,
    output logic                    branch,
    output logic                    branch_ne,
    output logic                    illegal,
    output logic                    illegal_seen
);

    alu_ctrl_t dec_ctrl;
    alu_ctrl_t ex_ctrl;
    logic      ex_valid;
    logic      seen_q;

    alu_ctrl_decode u_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .ctrl     (dec_ctrl)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
            seen_q   <= 1'b0;
        end else if (flush) begin
            // Flush wins over stall; the sticky flag is left alone.
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_BUBBLE;
        end else if (!stall) begin
            ex_valid <= in_valid;
            ex_ctrl  <= in_valid ? dec_ctrl : CTRL_BUBBLE;
            if (in_valid && dec_ctrl.illegal) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign out_valid    = ex_valid;
    assign ALUctrl      = ex_ctrl.alu_ctrl;
    assign ALUsrc       = ex_ctrl.alu_src;
    assign op1_sel      = ex_ctrl.op1_sel;
    assign branch       = ex_ctrl.branch;
    assign branch_ne    = ex_ctrl.branch_ne;
    assign illegal      = ex_ctrl.illegal;
    assign illegal_seen = seen_q;

endmodule : alu_ctrl_stage

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed scenarios plus a random
// run, all compared against an instruction-level reference model.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       stall;
    logic       flush;
    logic       out_valid;
    logic [2:0] ALUctrl;
    logic       ALUsrc;
    logic [1:0] op1_sel;
    logic       branch;
    logic       branch_ne;
    logic       illegal;
    logic       illegal_seen;

    int total = 0;
    int bad   = 0;

    alu_ctrl_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .stall        (stall),
        .flush        (flush),
        .out_valid    (out_valid),
        .ALUctrl      (ALUctrl),
        .ALUsrc       (ALUsrc),
        .op1_sel      (op1_sel),
        .branch       (branch),
        .branch_ne    (branch_ne),
        .illegal      (illegal),
        .illegal_seen (illegal_seen)
    );

    always #5 clk = ~clk;

    // {out_valid, ALUctrl, ALUsrc, op1_sel, branch, branch_ne, illegal, illegal_seen}
    logic [10:0] obs;
    assign obs = {out_valid, ALUctrl, ALUsrc, op1_sel, branch, branch_ne, illegal, illegal_seen};

    // ---------------- reference model ----------------
    logic       m_valid;
    logic [8:0] m_fields;   // {alu[2:0], src, op1[1:0], br, bne, ill}
    logic       m_seen;

    // Instruction-level meaning of each encoding, from the ISA subset table.
    function automatic logic [8:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7);
        logic [2:0] alu;
        logic       src;
        logic [1:0] op1;
        logic       br;
        logic       bne;
        logic       ill;
        alu = 3'd0; src = 1'b0; op1 = 2'd0; br = 1'b0; bne = 1'b0; ill = 1'b0;
        case (op)
            7'b0110011, 7'b0010011: begin
                src = (op == 7'b0010011);
                case (f3)
                    3'd0: alu = (!src && f7) ? 3'd1 : 3'd0;
                    3'd1: begin alu = 3'd2; ill = src && f7; end
                    3'd4: alu = 3'd4;
                    3'd5: begin alu = 3'd5; ill = f7; end
                    3'd6: alu = 3'd6;
                    3'd7: alu = 3'd7;
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111: src = 1'b1;
            7'b1100011: begin
                alu = 3'd1; br = 1'b1;
                if (f3 == 3'd1) bne = 1'b1;
                else if (f3 != 3'd0) ill = 1'b1;
            end
            7'b0110111: begin src = 1'b1; op1 = 2'b10; end
            7'b0010111, 7'b1101111: begin src = 1'b1; op1 = 2'b01; end
            default: ill = 1'b1;
        endcase
        if (ill) return 9'b0_0000_0001;
        return {alu, src, op1, br, bne, ill};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_valid, m_fields, m_seen};
    endfunction

    // Advance the model with the current inputs, then clock the DUT and
    // settle just after the edge.
    task automatic tick();
        logic [8:0] d;
        d = ref_decode(opcode, funct3, funct7_5);
        if (!rst_n) begin
            m_valid = 1'b0; m_fields = '0; m_seen = 1'b0;
        end else if (flush) begin
            m_valid = 1'b0; m_fields = '0;
        end else if (!stall) begin
            m_valid  = in_valid;
            m_fields = in_valid ? d : 9'd0;
            if (in_valid && d[0]) m_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7);
        in_valid = v; opcode = op; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== 11'd0) begin
                bad++; $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, 11'd0);
            end
        end
        rst_n = 1'b1;
        drive(1'b1, 7'b0110011, 3'b100, 1'b0);   // XOR
        tick();
        total++;
        if (out_valid !== 1'b1 || ALUctrl !== 3'b100 || obs !== exp_vec()) begin
            bad++; $display("FAIL first_load: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_r_type();
        drive(1'b1, 7'b0110011, 3'b000, 1'b1);
        tick();
        total++;
        if (ALUctrl !== 3'b001 || obs !== exp_vec()) begin
            bad++; $display("FAIL r_sub: got %b want %b", obs, exp_vec());
        end
        drive(1'b1, 7'b0110011, 3'b101, 1'b0);
        tick();
        total++;
        if (ALUctrl !== 3'b101 || obs !== exp_vec()) begin
            bad++; $display("FAIL r_srl: got %b want %b", obs, exp_vec());
        end
        total++;
        if (illegal_seen !== 1'b0) begin
            bad++; $display("FAIL seen_before_illegal: got %b want 0", illegal_seen);
        end
        drive(1'b1, 7'b0110011, 3'b010, 1'b0);   // SLT
        tick();
        total++;
        if (illegal !== 1'b1 || ALUctrl !== 3'b000 || illegal_seen !== 1'b1
            || obs !== exp_vec()) begin
            bad++; $display("FAIL r_slt_illegal: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_branch_lui();
        drive(1'b1, 7'b1100011, 3'b001, 1'b0);   // BNE
        tick();
        total++;
        if (ALUctrl !== 3'b001 || branch !== 1'b1 || branch_ne !== 1'b1 || ALUsrc !== 1'b0
            || obs !== exp_vec()) begin
            bad++; $display("FAIL bne: got %b want %b", obs, exp_vec());
        end
        drive(1'b1, 7'b0110111, 3'b011, 1'b1);   // LUI
        tick();
        total++;
        if (op1_sel !== 2'b10 || ALUsrc !== 1'b1 || obs !== exp_vec()) begin
            bad++; $display("FAIL lui: got %b want %b", obs, exp_vec());
        end
        drive(1'b1, 7'b0010111, 3'b000, 1'b0);   // AUIPC
        tick();
        total++;
        if (op1_sel !== 2'b01 || obs !== exp_vec()) begin
            bad++; $display("FAIL auipc: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 7'b0010011, 3'b000, 1'b1);   // ADDI
        tick();
        stall = 1'b1;
        drive(1'b1, 7'b0110011, 3'b100, 1'b0);   // XOR waiting in ID
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ALUctrl !== 3'b000 || ALUsrc !== 1'b1 || out_valid !== 1'b1
                || obs !== exp_vec()) begin
                bad++; $display("FAIL stall_hold[%0d]: got %b want %b", i, obs, exp_vec());
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (ALUctrl !== 3'b100 || ALUsrc !== 1'b0 || obs !== exp_vec()) begin
            bad++; $display("FAIL stall_release: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_flush_priority();
        do_reset();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 7'b1111111, 3'b000, 1'b0);
        tick();
        total++;
        if (obs !== 11'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL flush_over_stall: got %b want %b", obs, 11'd0);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_bubble();
        // Precondition: illegal_seen already set by test_r_type.
        drive(1'b0, 7'b1111111, 3'b000, 1'b0);
        tick();
        total++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || illegal_seen !== 1'b1
            || obs !== exp_vec()) begin
            bad++; $display("FAIL bubble: got %b want %b", obs, exp_vec());
        end
        drive(1'b1, 7'b0110011, 3'b111, 1'b0);   // AND
        tick();
        stall = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        total++;
        if (obs !== 11'd0 || obs !== exp_vec()) begin
            bad++; $display("FAIL reset_mid_stall: got %b want %b", obs, 11'd0);
        end
        rst_n = 1'b1; stall = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 9);
            drive($urandom_range(0, 9) != 0,
                  (k == 9) ? 7'($urandom) : ops[k],
                  3'($urandom), 1'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random[%0d]: got %b want %b", i, obs, exp_vec());
            end
            total++;
            if (ALUctrl === 3'b011) begin
                bad++; $display("FAIL reserved_code[%0d]: got %b want not 011", i, ALUctrl);
            end
        end
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] op_seq [6];
        logic [2:0] f3_seq [6];
        op_seq = '{7'b0110011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b1100011, 7'b0110011};
        f3_seq = '{3'b110,     3'b000,     3'b101,     3'b010,     3'b100,     3'b011};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, op_seq[i], f3_seq[i], 1'b0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        m_valid = 1'b0; m_fields = '0; m_seen = 1'b0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 1'b0);
        test_reset();
        test_branch_lui();
        test_stall();
        test_flush_priority();
        test_r_type();
        test_bubble();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_ctrl_stage
